// File: rtl/sig_lut_writer.sv
// sig_lut_writer: loadable piecewise-linear activation LUT with a 3-register lookup pipeline
// Ports:
//   clk, rst                      clock, async active-high reset
//   load_start                    pulse: restart table load at entry 0
//   wr_valid, wr_data, wr_ready   entry write handshake (ready only while loading)
//   load_done, table_ok           one-cycle load-complete pulse, table usable for lookups
//   z_valid, z_value              lookup request and pre-activation input
//   a_valid, a                    interpolated, saturated activation result
//   lut_err                       sticky: lookup requested without a loaded table
module sig_lut_writer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic signed [7:0] wr_data,
    output logic              wr_ready,
    output logic              load_done,
    output logic              table_ok,
    input  logic              z_valid,
    input  logic signed [7:0] z_value,
    output logic              a_valid,
    output logic signed [7:0] a,
    output logic              lut_err
);
    localparam int F = 8 - ADDR_W;
    localparam int N = 2 ** ADDR_W + 1;
    localparam int S = F + 10;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(2 ** ADDR_W);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t                 state, state_nx;
    logic [ADDR_W:0]        wp;
    logic signed [7:0]      entry [N];
    logic                   wr;
    logic [ADDR_W-1:0]      idx;
    logic [ADDR_W:0]        idx_n;
    logic                   v1, v2;
    logic signed [7:0]      base1, next1, base2;
    logic [F-1:0]           r1;
    logic signed [8:0]      diff;
    logic signed [F+9:0]    prod, prod2, sh;
    logic signed [S:0]      sum;
    logic [7:0]             sat;

    assign wr_ready = state == LOAD;
    assign table_ok = state == READY;
    assign wr       = wr_ready & wr_valid;
    assign idx      = z_value[7:F];
    assign idx_n    = {1'b0, idx} + 1'b1;
    assign diff     = {next1[7], next1} - {base1[7], base1};
    assign prod     = diff * $signed({1'b0, r1});
    assign sh       = prod2 >>> F;
    assign sum      = base2 + sh;
    // in range only when every bit from 7 upward agrees with the sign
    assign sat      = (&sum[S:7] | ~|sum[S:7]) ? sum[7:0] : {sum[S], {7{~sum[S]}}};

    always_comb begin
        state_nx = state;
        if (load_start)
            state_nx = LOAD;
        else if (wr && wp == LAST)
            state_nx = READY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wp        <= '0;
            load_done <= 1'b0;
            lut_err   <= 1'b0;
            for (int i = 0; i < N; i++)
                entry[i] <= '0;
        end else begin
            state     <= state_nx;
            wp        <= load_start ? '0 : wr ? wp + 1'b1 : wp;
            if (wr)
                entry[wp] <= wr_data;
            // a restart coinciding with the final write suppresses completion
            load_done <= wr && wp == LAST && !load_start;
            lut_err   <= load_start ? 1'b0 : (lut_err | (z_valid & ~table_ok));
        end
    end

    // stage 1 samples the table, so later reloads cannot disturb in-flight lookups
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            a_valid <= 1'b0;
            base1   <= '0;
            next1   <= '0;
            r1      <= '0;
            base2   <= '0;
            prod2   <= '0;
            a       <= '0;
        end else begin
            v1      <= z_valid & table_ok;
            base1   <= entry[idx];
            next1   <= entry[idx_n];
            r1      <= z_value[F-1:0];
            v2      <= v1;
            base2   <= base1;
            prod2   <= prod;
            a_valid <= v2;
            if (v2)
                a <= sat;
        end
    end
endmodule

// File: tb/tb_sig_lut_writer.sv
// tb_sig_lut_writer: directed self-checking bench for sig_lut_writer
module tb_sig_lut_writer;
    logic              clk = 1'b0;
    logic              rst, load_start, wr_valid, z_valid;
    logic signed [7:0] wr_data, z_value;
    logic              wr_ready, load_done, table_ok, a_valid, lut_err;
    logic signed [7:0] a;
    logic signed [7:0] tbl [17];
    int                checks = 0;
    int                errors = 0;

    sig_lut_writer #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .load_done(load_done),
        .table_ok(table_ok), .z_valid(z_valid), .z_value(z_value),
        .a_valid(a_valid), .a(a), .lut_err(lut_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_table_ok"}, table_ok, 0);
        check({tag, "_a_valid"}, a_valid, 0);
        check({tag, "_lut_err"}, lut_err, 0);
        check({tag, "_a"}, $signed(a), 0);
    endtask

    task automatic set_tbl(input int e15, input int e16);
        for (int i = 0; i < 15; i++)
            tbl[i] = 8'(8 * i);
        tbl[15] = 8'(e15);
        tbl[16] = 8'(e16);
    endtask

    task automatic load_tbl(input bit chk_en);
        int pulses;
        pulses = 0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        if (chk_en) begin
            check("ld_wr_ready", wr_ready, 1);
            check("ld_ok_clr", table_ok, 0);
            check("ld_err_clr", lut_err, 0);
        end
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = tbl[i];
            @(negedge clk);
            if (i < 16 && load_done)
                pulses++;
        end
        wr_valid = 1'b0;
        if (chk_en) begin
            check("ld_early_done", pulses, 0);
            check("ld_done", load_done, 1);
            check("ld_ok", table_ok, 1);
        end
        @(negedge clk);
        if (chk_en) begin
            check("ld_done_one", load_done, 0);
            check("ld_ok_hold", table_ok, 1);
            check("ld_ready_off", wr_ready, 0);
        end
    endtask

    task automatic lookup(input logic [7:0] z, input int exp);
        z_valid = 1'b1;
        z_value = z;
        @(negedge clk);
        z_valid = 1'b0;
        check("lk_lat1", a_valid, 0);
        @(negedge clk);
        check("lk_lat2", a_valid, 0);
        @(negedge clk);
        check("lk_valid", a_valid, 1);
        check("lk_a", $signed(a), exp);
        @(negedge clk);
        check("lk_valid_end", a_valid, 0);
    endtask

    task automatic early_lookup(input string tag);
        z_valid = 1'b1;
        z_value = 8'h23;
        @(negedge clk);
        z_valid = 1'b0;
        check({tag, "_err"}, lut_err, 1);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_no_valid"}, a_valid, 0);
            @(negedge clk);
        end
        check({tag, "_err_sticky"}, lut_err, 1);
    endtask

    initial begin
        logic [7:0] zs [4];
        int         ex [4];
        rst = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        z_valid = 1'b0; z_value = '0;
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_rst");

        early_lookup("early");

        set_tbl(120, 127);
        load_tbl(1'b1);
        lookup(8'h23, 17);
        lookup(8'h00, 0);
        lookup(8'h7F, 63);
        lookup(8'h80, 64);
        lookup(8'hF8, 123);

        zs = '{8'h23, 8'h00, 8'h7F, 8'hF8};
        ex = '{17, 0, 63, 123};
        for (int c = 0; c < 8; c++) begin
            if (c >= 3 && c <= 6) begin
                check("b2b_valid", a_valid, 1);
                check("b2b_a", $signed(a), ex[c-3]);
            end else
                check("b2b_idle", a_valid, 0);
            if (c == 5) begin
                check("b2b_ok_drop", table_ok, 0);
                check("b2b_wr_ready", wr_ready, 1);
            end
            z_valid    = c < 4;
            z_value    = zs[c % 4];
            load_start = c == 4;
            @(negedge clk);
        end
        check("b2b_no_err", lut_err, 0);

        set_tbl(120, -128);
        load_tbl(1'b0);
        lookup(8'hF8, -4);
        lookup(8'hFF, -113);
        set_tbl(127, -128);
        load_tbl(1'b0);
        lookup(8'hFF, -113);
        lookup(8'hF1, 111);
        set_tbl(-128, 127);
        load_tbl(1'b0);
        lookup(8'hFF, 111);
        lookup(8'hF1, -113);

        set_tbl(120, 127);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = tbl[i];
            @(negedge clk);
        end
        wr_data    = tbl[16];
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        wr_valid   = 1'b0;
        check("prio_no_done", load_done, 0);
        check("prio_wr_ready", wr_ready, 1);
        check("prio_ok", table_ok, 0);
        @(negedge clk);
        check("prio_no_done2", load_done, 0);
        load_tbl(1'b1);
        lookup(8'h23, 17);

        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = tbl[i];
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check_zero("mid_post");
        early_lookup("reload_req");
        load_tbl(1'b1);
        lookup(8'h23, 17);
        lookup(8'hF8, 123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
